// File: rtl/rx_pkg.sv
// rx_pkg: shared constants and types for the rx_tracker response tracker.
// Error-bit indices match the err_sticky layout {timeout, unexpected_ack, overflow}.
package rx_pkg;

  localparam int RX_NUM_SW_INST    = 5;
  localparam int RX_W_WIDTH        = 8;
  localparam int RX_ID_WIDTH       = 8;
  localparam int RX_DEPTH          = 2;
  localparam int RX_TIMEOUT_CYCLES = 64;

  localparam int ERR_OVF   = 0;
  localparam int ERR_UNEXP = 1;
  localparam int ERR_TMO   = 2;

  // One captured completion waiting for the arbiter. Field widths follow the
  // package defaults, so width overrides of rx_tracker must be mirrored here.
  typedef struct packed {
    logic [RX_ID_WIDTH-1:0] id;
    logic [RX_W_WIDTH-1:0]  data;
    logic                   err;
  } rx_hold_t;

endpackage

// File: rtl/rx_tracker_if.sv
// rx_tracker_if: select/ack inputs and tagged-response outputs of rx_tracker.
// master = decode/read-return side, slave = the tracker itself.
interface rx_tracker_if #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int ID_WIDTH    = 8
);
  localparam int IDX_W = $clog2(NUM_SW_INST);

  logic [NUM_SW_INST-1:0]         sel_en;
  logic [ID_WIDTH-1:0]            op_id;
  logic [NUM_SW_INST-1:0]         ack;
  logic [NUM_SW_INST*W_WIDTH-1:0] rd_data;
  logic [NUM_SW_INST-1:0]         ack_ready;
  logic [NUM_SW_INST-1:0]         sw_busy;
  logic                           rsp_valid;
  logic [IDX_W-1:0]               rsp_sw_idx;
  logic [ID_WIDTH-1:0]            op_id_out;
  logic [W_WIDTH-1:0]             rd_data_out;
  logic                           rsp_err;
  logic [2:0]                     err_sticky;

  modport master (
    output sel_en, op_id, ack, rd_data,
    input  ack_ready, sw_busy, rsp_valid, rsp_sw_idx, op_id_out, rd_data_out,
           rsp_err, err_sticky
  );

  modport slave (
    input  sel_en, op_id, ack, rd_data,
    output ack_ready, sw_busy, rsp_valid, rsp_sw_idx, op_id_out, rd_data_out,
           rsp_err, err_sticky
  );
endinterface

// File: rtl/rx_id_fifo.sv
// rx_id_fifo: small synchronous op_id FIFO, one per switch instance.
// A push into a full FIFO is accepted only when a pop happens in the same cycle;
// a pop of an empty FIFO is ignored.
module rx_id_fifo #(
  parameter int ID_WIDTH = 8,
  parameter int DEPTH    = 2,
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [ID_WIDTH-1:0] i_data,
  output logic [ID_WIDTH-1:0] o_data,
  output logic                o_full,
  output logic                o_empty,
  output logic [CW-1:0]       o_count
);

  logic [ID_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage array; contents are don't-care while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_tracker.sv
// rx_tracker: per-instance op_id FIFOs, ack capture into hold registers and a
// round-robin arbiter returning one tagged response per cycle.
// Optional feature macro: RX_TRACKER_TIMEOUT_EN (ack timeout per instance).
module rx_tracker
  import rx_pkg::*;
#(
  parameter int NUM_SW_INST    = RX_NUM_SW_INST,
  parameter int W_WIDTH        = RX_W_WIDTH,
  parameter int ID_WIDTH       = RX_ID_WIDTH,
  parameter int DEPTH          = RX_DEPTH,
  parameter int TIMEOUT_CYCLES = RX_TIMEOUT_CYCLES
) (
  input logic         clk,
  input logic         rst,
  rx_tracker_if.slave io_bus
);

  localparam int IDX_W = $clog2(NUM_SW_INST);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [NUM_SW_INST-1:0] w_push;
  logic [NUM_SW_INST-1:0] w_pop;
  logic [NUM_SW_INST-1:0] w_ack_ok;
  logic [NUM_SW_INST-1:0] w_ack_bad;
  logic [NUM_SW_INST-1:0] w_ovf;
  logic [NUM_SW_INST-1:0] w_tmo;
  logic [NUM_SW_INST-1:0] w_full;
  logic [NUM_SW_INST-1:0] w_empty;
  logic [NUM_SW_INST-1:0] w_busy;
  logic [NUM_SW_INST-1:0] w_grant;
  logic [NUM_SW_INST-1:0] w_ack_ready;
  logic [ID_WIDTH-1:0]    w_head  [NUM_SW_INST];
  logic [W_WIDTH-1:0]     w_slice [NUM_SW_INST];
  logic [CW-1:0]          w_count [NUM_SW_INST];
  logic                   w_found;
  logic                   w_any;
  logic [IDX_W-1:0]       w_gidx;
  rx_hold_t               w_gsel;
  int                     w_idx;

  logic [NUM_SW_INST-1:0] r_hold_v;
  rx_hold_t               r_hold [NUM_SW_INST];
  logic [IDX_W-1:0]       r_ptr;
  logic                   r_rsp_valid;
  logic [IDX_W-1:0]       r_rsp_idx;
  logic [ID_WIDTH-1:0]    r_rsp_id;
  logic [W_WIDTH-1:0]     r_rsp_data;
  logic                   r_rsp_err;
  logic [2:0]             r_err;

  genvar g;
  generate
    for (g = 0; g < NUM_SW_INST; g++) begin : g_fifo
      rx_id_fifo #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[g]),
        .i_pop   (w_pop[g]),
        .i_data  (io_bus.op_id),
        .o_data  (w_head[g]),
        .o_full  (w_full[g]),
        .o_empty (w_empty[g]),
        .o_count (w_count[g])
      );
    end
  endgenerate

  // Lowest set select bit wins; the others are ignored this cycle.
  always_comb begin
    w_push  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (io_bus.sel_en[i] && !w_found) begin
        w_push[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  // Classify acks, derive pops, overflows, per-instance data slices and busy flags.
  always_comb begin
    w_ack_ok  = '0;
    w_ack_bad = '0;
    w_pop     = '0;
    w_ovf     = '0;
    w_busy    = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      w_slice[i]   = io_bus.rd_data[i*W_WIDTH +: W_WIDTH];
      w_ack_ok[i]  = io_bus.ack[i] & w_ack_ready[i] & ~w_empty[i];
      w_ack_bad[i] = io_bus.ack[i] & ~(w_ack_ready[i] & ~w_empty[i]);
      w_pop[i]     = w_ack_ok[i] | w_tmo[i];
      w_ovf[i]     = w_push[i] & w_full[i] & ~w_pop[i];
      w_busy[i]    = (w_count[i] == CW'(DEPTH));
    end
  end

`ifdef RX_TRACKER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo_cnt [NUM_SW_INST];

  // Age the oldest entry of each non-empty FIFO; restart on every pop. Saturates
  // so a timeout blocked by a full hold fires as soon as the hold drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SW_INST; i++) r_tmo_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW_INST; i++) begin
        if (w_pop[i] || w_empty[i])
          r_tmo_cnt[i] <= '0;
        else if (r_tmo_cnt[i] != TW'(TIMEOUT_CYCLES - 1))
          r_tmo_cnt[i] <= r_tmo_cnt[i] + TW'(1);
      end
    end
  end

  // Timeout pop only into an empty hold, and a real ack in the same cycle wins.
  always_comb begin
    w_tmo = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      w_tmo[i] = ~w_empty[i] & (r_tmo_cnt[i] == TW'(TIMEOUT_CYCLES - 1)) &
                 ~r_hold_v[i] & ~w_ack_ok[i];
    end
  end
`else
  assign w_tmo = '0;
`endif

  // Round-robin search over pending holds starting at the pointer.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_gidx  = '0;
    w_gsel  = '0;
    w_idx   = 0;
    for (int off = 0; off < NUM_SW_INST; off++) begin
      w_idx = (int'(r_ptr) + off) % NUM_SW_INST;
      if (!w_any && r_hold_v[w_idx]) begin
        w_any          = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gidx         = IDX_W'(w_idx);
        w_gsel         = r_hold[w_idx];
      end
    end
  end

  // A hold being drained this cycle can be refilled by a same-cycle ack.
  assign w_ack_ready = ~r_hold_v | w_grant;

  // Capture popped entries into holds; a grant frees the hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_v <= '0;
      for (int i = 0; i < NUM_SW_INST; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW_INST; i++) begin
        if (w_pop[i]) begin
          r_hold_v[i]    <= 1'b1;
          r_hold[i].id   <= w_head[i];
          r_hold[i].data <= w_ack_ok[i] ? w_slice[i] : '0;
          r_hold[i].err  <= w_tmo[i];
        end else if (w_grant[i]) begin
          r_hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Register the granted response; outputs return to zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_rsp_valid <= w_any;
      if (w_any) begin
        r_rsp_idx  <= w_gidx;
        r_rsp_id   <= w_gsel.id;
        r_rsp_data <= w_gsel.data;
        r_rsp_err  <= w_gsel.err;
        r_ptr      <= (w_gidx == IDX_W'(NUM_SW_INST - 1)) ? '0 : w_gidx + IDX_W'(1);
      end else begin
        r_rsp_idx  <= '0;
        r_rsp_id   <= '0;
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b0;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err[ERR_OVF]   <= r_err[ERR_OVF]   | (|w_ovf);
      r_err[ERR_UNEXP] <= r_err[ERR_UNEXP] | (|w_ack_bad);
      r_err[ERR_TMO]   <= r_err[ERR_TMO]   | (w_any & w_gsel.err);
    end
  end

  assign io_bus.ack_ready   = w_ack_ready;
  assign io_bus.sw_busy     = w_busy;
  assign io_bus.rsp_valid   = r_rsp_valid;
  assign io_bus.rsp_sw_idx  = r_rsp_idx;
  assign io_bus.op_id_out   = r_rsp_id;
  assign io_bus.rd_data_out = r_rsp_data;
  assign io_bus.rsp_err     = r_rsp_err;
  assign io_bus.err_sticky  = r_err;

endmodule

// File: tb/tb_rx_tracker.sv
// tb_rx_tracker: directed self-checking bench for rx_tracker (default parameters,
// TIMEOUT_CYCLES=8 so the timeout scenario is short when the macro is defined).
module tb_rx_tracker;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int ID = 8;
  localparam int D  = 2;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rx_tracker_if #(.NUM_SW_INST(N), .W_WIDTH(W), .ID_WIDTH(ID)) bus ();

  rx_tracker #(
    .NUM_SW_INST(N), .W_WIDTH(W), .ID_WIDTH(ID), .DEPTH(D), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.sel_en  = '0;
    bus.op_id   = '0;
    bus.ack     = '0;
    bus.rd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input int idx, input logic [ID-1:0] id);
    bus.sel_en      = '0;
    bus.sel_en[idx] = 1'b1;
    bus.op_id       = id;
    tick();
    bus.sel_en = '0;
    bus.op_id  = '0;
  endtask

  task automatic set_data(input int idx, input logic [W-1:0] val);
    bus.rd_data[idx*W +: W] = val;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.ack_ready !== 5'h1F) begin failures++; $display("FAIL reset_ack_ready got=%h exp=1f", bus.ack_ready); end
    checks++; if (bus.sw_busy !== 5'h00) begin failures++; $display("FAIL reset_sw_busy got=%h exp=00", bus.sw_busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_sw_idx !== 3'd0) begin failures++; $display("FAIL reset_rsp_sw_idx got=%0d exp=0", bus.rsp_sw_idx); end
    checks++; if (bus.op_id_out !== 8'h00) begin failures++; $display("FAIL reset_op_id_out got=%h exp=00", bus.op_id_out); end
    checks++; if (bus.rd_data_out !== 8'h00) begin failures++; $display("FAIL reset_rd_data_out got=%h exp=00", bus.rd_data_out); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    checks++; if (bus.err_sticky !== 3'b000) begin failures++; $display("FAIL reset_err_sticky got=%b exp=000", bus.err_sticky); end
  endtask

  task automatic test_single();
    push(2, 8'h3C);
    checks++; if (bus.sw_busy !== 5'h00) begin failures++; $display("FAIL single_busy got=%h exp=00", bus.sw_busy); end
    tick();
    tick();
    bus.ack = 5'b00100;
    set_data(2, 8'hA5);
    tick();
    clear_inputs();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_sw_idx !== 3'd2) begin failures++; $display("FAIL single_idx got=%0d exp=2", bus.rsp_sw_idx); end
    checks++; if (bus.op_id_out !== 8'h3C) begin failures++; $display("FAIL single_id got=%h exp=3c", bus.op_id_out); end
    checks++; if (bus.rd_data_out !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.rd_data_out); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", bus.rsp_err); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_oneshot got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.op_id_out !== 8'h00 || bus.rd_data_out !== 8'h00) begin failures++; $display("FAIL single_idle_zero got=%h/%h exp=00/00", bus.op_id_out, bus.rd_data_out); end
  endtask

  task automatic test_overflow();
    push(0, 8'h01);
    checks++; if (bus.sw_busy !== 5'b00000) begin failures++; $display("FAIL ovf_busy1 got=%b exp=00000", bus.sw_busy); end
    push(0, 8'h02);
    checks++; if (bus.sw_busy !== 5'b00001) begin failures++; $display("FAIL ovf_busy2 got=%b exp=00001", bus.sw_busy); end
    push(0, 8'h03);
    checks++; if (bus.err_sticky !== 3'b001) begin failures++; $display("FAIL ovf_sticky got=%b exp=001", bus.err_sticky); end
    checks++; if (bus.sw_busy !== 5'b00001) begin failures++; $display("FAIL ovf_busy3 got=%b exp=00001", bus.sw_busy); end
    bus.ack = 5'b00001;
    set_data(0, 8'h10);
    tick();
    set_data(0, 8'h20);
    checks++; if (bus.ack_ready !== 5'h1F) begin failures++; $display("FAIL ovf_refill_ready got=%b exp=11111", bus.ack_ready); end
    tick();
    clear_inputs();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd0 || bus.op_id_out !== 8'h01 || bus.rd_data_out !== 8'h10) begin failures++; $display("FAIL ovf_first got=v%b i%0d id%h d%h exp=v1 i0 id01 d10", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd0 || bus.op_id_out !== 8'h02 || bus.rd_data_out !== 8'h20) begin failures++; $display("FAIL ovf_second got=v%b i%0d id%h d%h exp=v1 i0 id02 d20", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    checks++; if (bus.sw_busy !== 5'b00000) begin failures++; $display("FAIL ovf_drained got=%b exp=00000", bus.sw_busy); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL ovf_third_dropped got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_simultaneous();
    int         e_idx [3];
    logic [7:0] e_id  [3];
    logic [7:0] e_dat [3];
    e_idx = '{1, 3, 4};
    e_id  = '{8'h41, 8'h43, 8'h44};
    e_dat = '{8'hB1, 8'hB3, 8'hB4};
    push(1, 8'h41);
    push(3, 8'h43);
    push(4, 8'h44);
    bus.ack = 5'b11010;
    set_data(1, 8'hB1);
    set_data(3, 8'hB3);
    set_data(4, 8'hB4);
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'(e_idx[k]) || bus.op_id_out !== e_id[k] || bus.rd_data_out !== e_dat[k]) begin failures++; $display("FAIL simul_rsp%0d got=v%b i%0d id%h d%h exp=v1 i%0d id%h d%h", k, bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out, e_idx[k], e_id[k], e_dat[k]); end
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL simul_done got=%b exp=0", bus.rsp_valid); end
    // Single grant on 2 moves the pointer to 3, so a 1+4 round must serve 4 first.
    push(2, 8'h52);
    bus.ack = 5'b00100;
    set_data(2, 8'hC2);
    tick();
    clear_inputs();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd2) begin failures++; $display("FAIL wrap_pre got=v%b i%0d exp=v1 i2", bus.rsp_valid, bus.rsp_sw_idx); end
    push(1, 8'h61);
    push(4, 8'h64);
    bus.ack = 5'b10010;
    set_data(1, 8'hD1);
    set_data(4, 8'hD4);
    tick();
    clear_inputs();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd4 || bus.op_id_out !== 8'h64 || bus.rd_data_out !== 8'hD4) begin failures++; $display("FAIL wrap_first got=v%b i%0d id%h d%h exp=v1 i4 id64 dd4", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd1 || bus.op_id_out !== 8'h61 || bus.rd_data_out !== 8'hD1) begin failures++; $display("FAIL wrap_second got=v%b i%0d id%h d%h exp=v1 i1 id61 dd1", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    tick();
  endtask

  task automatic test_unexpected();
    do_reset();
    bus.ack = 5'b00001;
    set_data(0, 8'hEE);
    tick();
    clear_inputs();
    checks++; if (bus.err_sticky !== 3'b010) begin failures++; $display("FAIL unexp_sticky got=%b exp=010", bus.err_sticky); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL unexp_norsp got=%b exp=0", bus.rsp_valid); end
    do_reset();
    push(1, 8'h51);
    push(1, 8'h52);
    checks++; if (bus.sw_busy !== 5'b00010) begin failures++; $display("FAIL notready_busy got=%b exp=00010", bus.sw_busy); end
    push(2, 8'h61);
    bus.ack = 5'b00110;
    set_data(1, 8'hC1);
    set_data(2, 8'hC2);
    tick();
    checks++; if (bus.ack_ready !== 5'b11011) begin failures++; $display("FAIL notready_ready got=%b exp=11011", bus.ack_ready); end
    checks++; if (bus.err_sticky !== 3'b000) begin failures++; $display("FAIL notready_clean got=%b exp=000", bus.err_sticky); end
    bus.ack = 5'b00100;
    set_data(2, 8'hC9);
    tick();
    checks++; if (bus.err_sticky !== 3'b010) begin failures++; $display("FAIL notready_sticky got=%b exp=010", bus.err_sticky); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd1 || bus.op_id_out !== 8'h51 || bus.rd_data_out !== 8'hC1) begin failures++; $display("FAIL notready_rsp1 got=v%b i%0d id%h d%h exp=v1 i1 id51 dc1", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    clear_inputs();
    bus.ack = 5'b00010;
    set_data(1, 8'hC3);
    tick();
    clear_inputs();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd2 || bus.op_id_out !== 8'h61 || bus.rd_data_out !== 8'hC2) begin failures++; $display("FAIL notready_rsp2 got=v%b i%0d id%h d%h exp=v1 i2 id61 dc2", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sw_idx !== 3'd1 || bus.op_id_out !== 8'h52 || bus.rd_data_out !== 8'hC3) begin failures++; $display("FAIL notready_rsp3 got=v%b i%0d id%h d%h exp=v1 i1 id52 dc3", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.sw_busy !== 5'b00000) begin failures++; $display("FAIL notready_end got=v%b busy%b exp=v0 busy00000", bus.rsp_valid, bus.sw_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(0, 8'h71);
    push(1, 8'h72);
    push(3, 8'h73);
    push(3, 8'h74);
    push(4, 8'h75);
    bus.ack = 5'b00011;
    set_data(0, 8'hE0);
    set_data(1, 8'hE1);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_sw_idx !== 3'd0 || bus.op_id_out !== 8'h00 || bus.rd_data_out !== 8'h00) begin failures++; $display("FAIL mid_rsp got=v%b i%0d id%h d%h exp=v0 i0 id00 d00", bus.rsp_valid, bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out); end
    checks++; if (bus.ack_ready !== 5'h1F || bus.sw_busy !== 5'h00) begin failures++; $display("FAIL mid_flags got=ready%b busy%b exp=ready11111 busy00000", bus.ack_ready, bus.sw_busy); end
    checks++; if (bus.err_sticky !== 3'b000 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b/%b exp=000/0", bus.err_sticky, bus.rsp_err); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_quiet%0d got=%b exp=0", k, bus.rsp_valid); end
    end
    bus.ack = 5'b01000;
    set_data(3, 8'h99);
    tick();
    clear_inputs();
    checks++; if (bus.err_sticky !== 3'b010) begin failures++; $display("FAIL mid_flushed got=%b exp=010", bus.err_sticky); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_flushed_rsp got=%b exp=0", bus.rsp_valid); end
  endtask

`ifdef RX_TRACKER_TIMEOUT_EN
  task automatic test_timeout();
    int  n;
    logic seen;
    do_reset();
    push(1, 8'h11);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      tick();
      n++;
      seen = bus.rsp_valid;
    end
    checks++; if (!seen) begin failures++; $display("FAIL tmo_wait got=no_rsp exp=rsp_within_30"); end
    else begin
      checks++; if (n !== 9) begin failures++; $display("FAIL tmo_latency got=%0d exp=9", n); end
      checks++; if (bus.rsp_sw_idx !== 3'd1 || bus.op_id_out !== 8'h11 || bus.rd_data_out !== 8'h00 || bus.rsp_err !== 1'b1) begin failures++; $display("FAIL tmo_rsp got=i%0d id%h d%h e%b exp=i1 id11 d00 e1", bus.rsp_sw_idx, bus.op_id_out, bus.rd_data_out, bus.rsp_err); end
      checks++; if (bus.err_sticky !== 3'b100) begin failures++; $display("FAIL tmo_sticky got=%b exp=100", bus.err_sticky); end
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL tmo_after got=v%b e%b exp=v0 e0", bus.rsp_valid, bus.rsp_err); end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_overflow();
    test_simultaneous();
    test_unexpected();
    test_reset_mid();
`ifdef RX_TRACKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
